// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result-source encodings,
// the control bundle carried through ID/EX and the canonical NOP word.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Control bundle registered into ID/EX alongside the data payload.
    typedef struct packed {
        alu_ctrl_e   alu_ctrl;
        logic        alu_src;
        result_src_e result_src;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        is_load;
        logic        illegal;
    } ctrl_t;

    // funct3 (and the funct7 subtract bit for R-type) to ALU operation.
    // Encodings without an ALU operation here fall back to add.
    function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3, input logic sub);
        alu_ctrl_e v;
        case (funct3)
            3'b000:  v = sub ? ALU_SUB : ALU_ADD;
            3'b111:  v = ALU_AND;
            3'b110:  v = ALU_OR;
            3'b100:  v = ALU_XOR;
            3'b010:  v = ALU_SLT;
            default: v = ALU_ADD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction. Selects the I/S/B/J/U
// layout from the opcode and sign-extends to XLEN; other opcodes give zero.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    // Pick the immediate layout that matches the opcode.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves o_imm unassigned (no latch).
        o_imm = '0;
        case (i_instr[6:0])
            OP_IALU, OP_LOAD: o_imm = XLEN'($signed(i_instr[31:20]));
            OP_STORE:         o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            OP_BRANCH:        o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                                     i_instr[11:8], 1'b0}));
            OP_JAL:           o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                                     i_instr[30:21], 1'b0}));
            OP_LUI:           o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            default:          o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage RV32I pipeline. Decodes the IF/ID
// instruction, drives register-file read addresses, detects load-use and
// writeback hazards, and fills the ID/EX register under valid/ready.
// Optional build macro DECODE_WB_BYPASS_EN: forward writeback data into the
// captured operands instead of stalling on a writeback collision.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid_i,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            id_ready_o,
    input  logic            flush_i,
    output logic [RA_W-1:0] rf_a1_o,
    output logic [RA_W-1:0] rf_a2_o,
    input  logic [XLEN-1:0] rf_rd1_i,
    input  logic [XLEN-1:0] rf_rd2_i,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [RA_W-1:0] ex_rd_o,
    output logic [2:0]      ex_alu_ctrl_o,
    output logic            ex_alu_src_o,
    output logic [1:0]      ex_result_src_o,
    output logic            ex_mem_write_o,
    output logic            ex_reg_write_o,
    output logic            ex_branch_o,
    output logic            ex_jump_o,
    output logic            ex_is_load_o,
    output logic            ex_illegal_o
);

`ifdef DECODE_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    // Instruction fields.
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7_5;
    logic [RA_W-1:0] w_rs1;
    logic [RA_W-1:0] w_rs2;
    logic [RA_W-1:0] w_rd;

    assign w_opcode   = if_instr_i[6:0];
    assign w_funct3   = if_instr_i[14:12];
    assign w_funct7_5 = if_instr_i[30];
    assign w_rs1      = if_instr_i[19:15];
    assign w_rs2      = if_instr_i[24:20];
    assign w_rd       = if_instr_i[11:7];

    assign rf_a1_o = w_rs1;
    assign rf_a2_o = w_rs2;

    // Decoded control and source usage.
    ctrl_t           w_ctrl;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic [XLEN-1:0] w_imm;

    // ID/EX pipeline register.
    logic            r_ex_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rd;
    ctrl_t           r_ctrl;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (if_instr_i),
        .o_imm   (w_imm)
    );

    // Opcode decode into control flags and which sources the instruction reads.
    always_comb begin
        w_ctrl    = '0;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.alu_ctrl  = alu_from_funct(w_funct3, w_funct7_5);
                w_ctrl.reg_write = 1'b1;
                w_use_rs2        = 1'b1;
            end
            OP_IALU: begin
                w_ctrl.alu_ctrl  = alu_from_funct(w_funct3, 1'b0);
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_LOAD: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = RES_MEM;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.is_load    = 1'b1;
            end
            OP_STORE: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_use_rs2        = 1'b1;
            end
            OP_BRANCH: begin
                w_ctrl.alu_ctrl = ALU_SUB;
                w_ctrl.branch   = 1'b1;
                w_use_rs2       = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = RES_PC4;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_use_rs1         = 1'b0;
            end
            OP_LUI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_use_rs1        = 1'b0;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
        // Writes to x0 are discarded.
        if (w_rd == '0) w_ctrl.reg_write = 1'b0;
    end

    // Hazard detection and operand selection.
    logic            w_adv;
    logic            w_ld_hit;
    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic            w_haz;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_adv     = !r_ex_valid || ex_ready_i;
    assign w_ld_hit  = r_ex_valid && r_ctrl.is_load && (r_rd != '0) &&
                       ((w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2)));
    assign w_wb_hit1 = wb_we_i && (wb_rd_i != '0) && w_use_rs1 && (wb_rd_i == w_rs1);
    assign w_wb_hit2 = wb_we_i && (wb_rd_i != '0) && w_use_rs2 && (wb_rd_i == w_rs2);

    // With forwarding the writeback value replaces the stale register-file read;
    // without it the collision stalls so the retry sees the updated file.
    assign w_haz      = if_valid_i && (w_ld_hit || (!WB_BYPASS && (w_wb_hit1 || w_wb_hit2)));
    assign w_rs1_data = (WB_BYPASS && w_wb_hit1) ? wb_data_i : rf_rd1_i;
    assign w_rs2_data = (WB_BYPASS && w_wb_hit2) ? wb_data_i : rf_rd2_i;

    assign id_ready_o = w_adv && !w_haz && !flush_i;

    // ID/EX register: reset, flush, bubble, capture, or hold under backpressure.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update tied to the same edge.
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else if (flush_i) begin
            r_ex_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_haz || !if_valid_i) begin
                r_ex_valid <= 1'b0;
            end else begin
                r_ex_valid <= 1'b1;
                r_pc       <= if_pc_i;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= w_imm;
                r_rd       <= w_rd;
                r_ctrl     <= w_ctrl;
            end
        end
    end

    assign ex_valid_o      = r_ex_valid;
    assign ex_pc_o         = r_pc;
    assign ex_rs1_data_o   = r_rs1_data;
    assign ex_rs2_data_o   = r_rs2_data;
    assign ex_imm_o        = r_imm;
    assign ex_rd_o         = r_rd;
    assign ex_alu_ctrl_o   = r_ctrl.alu_ctrl;
    assign ex_alu_src_o    = r_ctrl.alu_src;
    assign ex_result_src_o = r_ctrl.result_src;
    assign ex_mem_write_o  = r_ctrl.mem_write;
    assign ex_reg_write_o  = r_ctrl.reg_write;
    assign ex_branch_o     = r_ctrl.branch;
    assign ex_jump_o       = r_ctrl.jump;
    assign ex_is_load_o    = r_ctrl.is_load;
    assign ex_illegal_o    = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// instruction streams, compared against a behavioural model of the ID/EX register.
module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        id_ready_o;
    logic        flush_i;
    logic [4:0]  rf_a1_o, rf_a2_o;
    logic [31:0] rf_rd1_i, rf_rd2_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        ex_ready_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rd_o;
    logic [2:0]  ex_alu_ctrl_o;
    logic        ex_alu_src_o;
    logic [1:0]  ex_result_src_o;
    logic        ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o, ex_is_load_o, ex_illegal_o;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .id_ready_o(id_ready_o), .flush_i(flush_i),
        .rf_a1_o(rf_a1_o), .rf_a2_o(rf_a2_o), .rf_rd1_i(rf_rd1_i), .rf_rd2_i(rf_rd2_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
        .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_alu_ctrl_o(ex_alu_ctrl_o),
        .ex_alu_src_o(ex_alu_src_o), .ex_result_src_o(ex_result_src_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
        .ex_is_load_o(ex_is_load_o), .ex_illegal_o(ex_illegal_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected ID/EX contents.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rd;
        logic [2:0]  alu;
        logic        src;
        logic [1:0]  res;
        logic        mw, rw, br, j, ld, ill;
    } exp_t;

    exp_t m;
    logic last_ready;

    function automatic bit reads_rs1(input logic [31:0] ins);
        return !(ins[6:0] == 7'b1101111 || ins[6:0] == 7'b0110111);
    endfunction

    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0100011 || ins[6:0] == 7'b1100011;
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        return (reads_rs1(ins) && r == ins[19:15]) || (reads_rs2(ins) && r == ins[24:20]);
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            3'd2:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Architectural decode of one instruction into the expected ID/EX contents.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] d1, input logic [31:0] d2);
        exp_t e = '0;
        logic [31:0] sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        logic [4:0]  rd = ins[11:7];
        e.valid = 1'b1;
        e.pc    = pc;
        e.rs1d  = d1;
        e.rs2d  = d2;
        e.rd    = rd;
        case (ins[6:0])
            7'b0110011: begin e.alu = alu_of(ins[14:12], ins[30]); e.rw = 1; end
            7'b0010011: begin e.alu = alu_of(ins[14:12], 0); e.src = 1; e.rw = 1;
                              e.imm = (sx << 12) | (ins >> 20); end
            7'b0000011: begin e.src = 1; e.res = 2'd1; e.rw = 1; e.ld = 1;
                              e.imm = (sx << 12) | (ins >> 20); end
            7'b0100011: begin e.src = 1; e.mw = 1;
                              e.imm = (sx << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'd31); end
            7'b1100011: begin e.alu = 3'd1; e.br = 1;
                              e.imm = (sx << 12) | (((ins >> 7) & 32'd1) << 11)
                                    | (((ins >> 25) & 32'd63) << 5) | (((ins >> 8) & 32'd15) << 1); end
            7'b1101111: begin e.src = 1; e.res = 2'd2; e.rw = 1; e.j = 1;
                              e.imm = (sx << 20) | (ins & 32'h000F_F000)
                                    | (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'd1023) << 1); end
            7'b0110111: begin e.src = 1; e.rw = 1; e.imm = ins & 32'hFFFF_F000; end
            default:    e.ill = 1;
        endcase
        if (rd == 5'd0) e.rw = 0;
        return e;
    endfunction

    // One clock: check combinational outputs, advance the model, check ID/EX.
    task automatic cycle();
        bit adv, haz, rdy, chk_all, c1, c2;
        exp_t nxt;
        #1;
        adv = !m.valid || ex_ready_i;
        haz = if_valid_i && ((m.valid && m.ld && m.rd != 0 && reads_reg(if_instr_i, m.rd)) ||
                             (!BYP && wb_we_i && wb_rd_i != 0 && reads_reg(if_instr_i, wb_rd_i)));
        rdy = adv && !haz && !flush_i;
        check("id_ready", {31'b0, id_ready_o}, {31'b0, rdy});
        check("rf_a1", {27'b0, rf_a1_o}, {27'b0, if_instr_i[19:15]});
        check("rf_a2", {27'b0, rf_a2_o}, {27'b0, if_instr_i[24:20]});
        last_ready = id_ready_o;
        c1  = BYP && wb_we_i && wb_rd_i != 0 && reads_rs1(if_instr_i) && wb_rd_i == if_instr_i[19:15];
        c2  = BYP && wb_we_i && wb_rd_i != 0 && reads_rs2(if_instr_i) && wb_rd_i == if_instr_i[24:20];
        nxt = ref_decode(if_instr_i, if_pc_i, c1 ? wb_data_i : rf_rd1_i, c2 ? wb_data_i : rf_rd2_i);
        chk_all = rst;
        @(posedge clk);
        if (rst)                          m = '0;
        else if (flush_i)                 m.valid = 1'b0;
        else if (adv && (haz || !if_valid_i)) m.valid = 1'b0;
        else if (adv)                     m = nxt;
        #1;
        check("ex_valid", {31'b0, ex_valid_o}, {31'b0, m.valid});
        if (m.valid || chk_all) begin
            check("ex_pc", ex_pc_o, m.pc);
            check("ex_rs1_data", ex_rs1_data_o, m.rs1d);
            check("ex_rs2_data", ex_rs2_data_o, m.rs2d);
            check("ex_imm", ex_imm_o, m.imm);
            check("ex_rd", {27'b0, ex_rd_o}, {27'b0, m.rd});
            check("ex_alu_ctrl", {29'b0, ex_alu_ctrl_o}, {29'b0, m.alu});
            check("ex_alu_src", {31'b0, ex_alu_src_o}, {31'b0, m.src});
            check("ex_result_src", {30'b0, ex_result_src_o}, {30'b0, m.res});
            check("ex_flags",
                  {26'b0, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o, ex_is_load_o, ex_illegal_o},
                  {26'b0, m.mw, m.rw, m.br, m.j, m.ld, m.ill});
        end
    endtask

    task automatic idle();
        rst = 0; if_valid_i = 0; flush_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0; ex_ready_i = 1;
        if_instr_i = 32'h0000_0013; if_pc_i = 0; rf_rd1_i = 0; rf_rd2_i = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [2:0]  f3s [5] = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
        logic [6:0]  bad [4] = '{7'b0001111, 7'b1110011, 7'b1100111, 7'b0010111};
        logic [31:0] r  = $urandom();
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  s1 = 5'($urandom_range(0, 7));
        logic [4:0]  s2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3 = f3s[$urandom_range(0, 4)];
        case ($urandom_range(0, 7))
            0: return {(f3 == 0 && r[0]) ? 7'h20 : 7'h00, s2, s1, f3, rd, 7'b0110011};
            1: return {r[11:0], s1, f3, rd, 7'b0010011};
            2: return {r[11:0], s1, 3'b010, rd, 7'b0000011};
            3: return {r[31:25], s2, s1, 3'b010, r[4:0], 7'b0100011};
            4: return {r[31:25], s2, s1, 2'b00, r[12], r[4:0], 7'b1100011};
            5: return {r[19:0], rd, 7'b1101111};
            6: return {r[31:12], rd, 7'b0110111};
            default: return {r[24:0], bad[$urandom_range(0, 3)]};
        endcase
    endfunction

    initial begin
        m = '0;
        idle();
        rst = 1;
        cycle(); cycle();
        rst = 0;

        // addi x5,x0,-3
        if_valid_i = 1; if_instr_i = 32'hFFD0_0293; if_pc_i = 32'h100; rf_rd1_i = 0;
        cycle();
        check("addi_imm", ex_imm_o, 32'hFFFF_FFFD);
        check("addi_src", {31'b0, ex_alu_src_o}, 32'd1);
        check("addi_alu", {29'b0, ex_alu_ctrl_o}, 32'd0);
        check("addi_rd", {27'b0, ex_rd_o}, 32'd5);
        check("addi_rw", {31'b0, ex_reg_write_o}, 32'd1);

        // lw x6,0(x1) then add x7,x6,x2: one bubble, add accepted next cycle
        if_instr_i = 32'h0000_A303; if_pc_i = 32'h104;
        cycle();
        if_instr_i = 32'h0023_03B3; if_pc_i = 32'h108;
        cycle();
        check("lu_stall_ready", {31'b0, last_ready}, 32'd0);
        check("lu_bubble", {31'b0, ex_valid_o}, 32'd0);
        cycle();
        check("lu_retry_ready", {31'b0, last_ready}, 32'd1);
        check("lu_add_rd", {27'b0, ex_rd_o}, 32'd7);

        // Backpressure for three cycles, then resume
        if_instr_i = 32'h0010_0493; if_pc_i = 32'h10C; ex_ready_i = 0;
        repeat (3) begin
            cycle();
            check("bp_ready", {31'b0, last_ready}, 32'd0);
            check("bp_hold_rd", {27'b0, ex_rd_o}, 32'd7);
        end
        ex_ready_i = 1;
        cycle();
        check("bp_resume_rd", {27'b0, ex_rd_o}, 32'd9);

        // Flush with a valid instruction
        flush_i = 1; if_pc_i = 32'h110;
        cycle();
        check("flush_ready", {31'b0, last_ready}, 32'd0);
        check("flush_valid", {31'b0, ex_valid_o}, 32'd0);
        flush_i = 0;

        // Writeback collision: add x8,x6,x6 with x6 being written back
        if_instr_i = 32'h0063_0433; if_pc_i = 32'h114;
        wb_we_i = 1; wb_rd_i = 6; wb_data_i = 32'h1234; rf_rd1_i = 32'hDEAD; rf_rd2_i = 32'hBEEF;
        cycle();
        if (BYP) begin
            check("wb_byp_ready", {31'b0, last_ready}, 32'd1);
            check("wb_byp_rs1", ex_rs1_data_o, 32'h1234);
            check("wb_byp_rs2", ex_rs2_data_o, 32'h1234);
        end else begin
            check("wb_stall_ready", {31'b0, last_ready}, 32'd0);
            wb_we_i = 0; rf_rd1_i = 32'h1234; rf_rd2_i = 32'h1234;
            cycle();
            check("wb_retry_ready", {31'b0, last_ready}, 32'd1);
            check("wb_retry_rd", {27'b0, ex_rd_o}, 32'd8);
        end
        wb_we_i = 0;

        // Reset mid-stream with a valid instruction in ID/EX
        if_instr_i = 32'h0010_0493; if_pc_i = 32'h118;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        check("post_rst_ready", {31'b0, last_ready}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if_valid_i = ($urandom_range(0, 99) < 85);
            if_instr_i = rand_instr();
            if_pc_i    = $urandom() & 32'hFFFF_FFFC;
            rf_rd1_i   = $urandom();
            rf_rd2_i   = $urandom();
            wb_we_i    = ($urandom_range(0, 99) < 30);
            wb_rd_i    = 5'($urandom_range(0, 7));
            wb_data_i  = $urandom();
            ex_ready_i = ($urandom_range(0, 99) < 75);
            flush_i    = ($urandom_range(0, 99) < 8);
            rst        = ($urandom_range(0, 999) < 5);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline; sits between the IF/ID register and execute.
- Decodes the fetched instruction and drives the register-file read addresses combinationally.
- Captures the register-file read data, the immediate and the control signals into the ID/EX pipeline register.
- Detects load-use and writeback hazards, and stalls fetch with a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_valid_i  in  1  IF/ID holds a valid instruction.
- if_instr_i  in  32  instruction word.
- if_pc_i  in  XLEN  PC of the instruction.
- id_ready_o  out  1  ID accepts the instruction this cycle.
- flush_i  in  1  kill the instruction in ID and the ID/EX contents (taken branch/jump).
- rf_a1_o, rf_a2_o  out  RA_W  register-file read addresses = instr[19:15], instr[24:20].
- rf_rd1_i, rf_rd2_i  in  XLEN  register-file read data, combinational.
- wb_we_i  in  1  writeback write enable.
- wb_rd_i  in  RA_W  writeback destination register.
- wb_data_i  in  XLEN  writeback data.
- ex_ready_i  in  1  execute accepts the ID/EX contents.
- ex_valid_o  out  1  ID/EX holds a valid instruction.
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN  ID/EX payload.
- ex_rd_o  out  RA_W  destination register.
- ex_alu_ctrl_o  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- ex_alu_src_o  out  1  1 = immediate operand.
- ex_result_src_o  out  2  00 ALU, 01 memory, 10 PC+4.
- ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o, ex_is_load_o, ex_illegal_o  out  1  control flags.

Behaviour:
- Reset: on rst at posedge, all ex_* outputs become 0, including ex_valid_o. rst wins over every other input.
- Decoded opcodes:
  - R-type 0110011
  - I-ALU 0010011
  - LW 0000011
  - SW 0100011
  - BEQ/BNE 1100011
  - JAL 1101111
  - LUI 0110111
- Immediates are sign-extended per RV32I I/S/B/J format. U-format is imm<<12.
- Illegal instruction (any other opcode):
  - Passes through with ex_illegal_o=1.
  - ex_reg_write_o=0, ex_mem_write_o=0.
- ex_rd_o is forced to 0, and ex_reg_write_o to 0, when instr[11:7]==0.
- Advance condition: adv = !ex_valid_o | ex_ready_i.
- Hazard, haz = if_valid_i AND either:
  - Load-use: ex_valid_o & ex_is_load_o & ex_rd_o!=0 & ex_rd_o equals a source register the instruction uses.
  - Writeback collision (only without the macro): wb_we_i & wb_rd_i!=0 & wb_rd_i equals a used source.
- Source usage by format:
  - rs1 unused by JAL and LUI.
  - rs2 used only by R-type, SW and BEQ/BNE.
- id_ready_o = adv & !haz & !flush_i.
- At posedge, in priority order:
  1. flush_i: ex_valid_o<=0.
  2. adv & haz: bubble inserted, ex_valid_o<=0; IF must hold its instruction.
  3. adv & if_valid_i: capture, ex_valid_o<=1.
  4. adv & !if_valid_i: ex_valid_o<=0.
  5. !adv: ID/EX holds all fields unchanged.
- Latency: one cycle from acceptance to ex_valid_o.
- Throughput: one instruction per cycle absent hazards.
- A load-use stall lasts exactly one cycle: the load leaves EX, clearing the condition.
- flush_i together with a hazard: flush wins, no stall cycle counted.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined:
  - On a writeback collision, the captured rs1/rs2 data is wb_data_i instead of rf_rd*_i.
  - No writeback stall is generated.
  - Each source is checked separately.
- Undefined:
  - A writeback collision stalls one cycle, so the register file is already updated on the retry.

Decomposition:
- Package riscv_pkg holds:
  - Opcode constants.
  - ALU control encodings.
  - Result-source encodings.
  - NOP word 32'h00000013.
- One sub-module, imm_gen: purely combinational, instruction to sign-extended immediate by format.

Test Plan:
- Reset mid-stream: rst for one cycle while ex_valid_o=1 -> next cycle all ex_* are 0 and id_ready_o=1 (given if_valid_i=1, ex_ready_i=1).
- addi x5,x0,-3 (0xFFD00293), rf_rd1_i=0 -> one cycle later ex_imm_o=0xFFFFFFFD, ex_alu_src_o=1, ex_alu_ctrl_o=000, ex_rd_o=5, ex_reg_write_o=1.
- lw x6,0(x1) then add x7,x6,x2:
  - id_ready_o=0 for one cycle and a bubble (ex_valid_o=0) is inserted.
  - The add is accepted on the next cycle.
- Backpressure: ex_ready_i=0 for 3 cycles -> ID/EX fields stable and id_ready_o=0; resumes the cycle ex_ready_i returns to 1.
- flush_i=1 with a valid instruction -> ex_valid_o=0 next cycle and id_ready_o=0 that cycle.
- Writeback collision: wb_we_i=1, wb_rd_i=6, wb_data_i=0x1234, instruction add x8,x6,x6:
  - With DECODE_WB_BYPASS_EN: both rs1 and rs2 data captured as 0x1234, no stall.
  - Without it: one stall cycle, then the instruction is captured.
